// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the output serializer slice.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] block_t;

  function automatic int words_per_block(input int word_w);
    return AES_BLOCK_W / word_w;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// DEPTH x 128-bit block FIFO. Callers guarantee push only when not full
// (or full with a same-cycle pop) and pop only when not empty.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  block_t        wdata,
  output block_t        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  block_t           mem [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;

  // Block storage; data needs no reset because reads are gated by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_r] <= wdata;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r <= {PTR_W{1'b0}};
      rptr_r <= {PTR_W{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wptr_r <= (wptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wptr_r + 1'b1;
      end
      if (pop) begin
        rptr_r <= (rptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rptr_r + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rptr_r];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == {CW{1'b0}});

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers AES result blocks and streams them MS-word first on valid/ready.
// Optional macro AES_OUT_COMPLEMENT_CHECK_EN adds a complement fault check.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              AES_clk,
  input  logic              AES_rst,
  input  logic              AES_data_out_valid,
  input  logic [127:0]      AES_data_out,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  blocks_cnt
`ifdef AES_OUT_COMPLEMENT_CHECK_EN
  ,
  input  logic [127:0]      AES_data_out_complementary,
  output logic              cmp_err
`endif
);

  localparam int NW    = words_per_block(WORD_W);
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int FCW   = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  block_t           head_s;
  logic [FCW-1:0]   count_s;
  logic             full_s;
  logic             empty_s;
  logic             valid_s;
  logic             last_s;
  logic             xfer_s;
  logic             push_s;
  logic             pop_s;
  logic             cand_s;
  logic             drop_s;
  logic [6:0]       top_s;
  logic [IDX_W-1:0] word_idx_r;
`ifdef AES_OUT_COMPLEMENT_CHECK_EN
  logic             cmp_bad_s;
`endif

  aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (AES_clk),
    .rst   (AES_rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (AES_data_out),
    .head  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Handshake, push/drop decisions and word selection
  always_comb begin
    valid_s = (count_s != {FCW{1'b0}});
    last_s  = valid_s && (word_idx_r == LAST_IDX);
    xfer_s  = valid_s && out_ready;
    pop_s   = xfer_s && last_s && !empty_s;
`ifdef AES_OUT_COMPLEMENT_CHECK_EN
    cmp_bad_s = AES_data_out_valid && (AES_data_out_complementary != ~AES_data_out);
    cand_s    = AES_data_out_valid && !cmp_bad_s;
`else
    cand_s    = AES_data_out_valid;
`endif
    // A full FIFO still accepts when its head block leaves this same cycle
    push_s = cand_s && (!full_s || pop_s);
    drop_s = cand_s && full_s && !pop_s;
    top_s  = 7'(AES_BLOCK_W - 1) - 7'(WORD_W * int'(word_idx_r));
    if (valid_s) begin
      out_data = head_s[top_s -: WORD_W];
    end else begin
      out_data = {WORD_W{1'b0}};
    end
    out_valid = valid_s;
    out_last  = last_s;
  end

  // Word position within the head block and emitted-block counter
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      word_idx_r <= {IDX_W{1'b0}};
      blocks_cnt <= {CNT_W{1'b0}};
    end else if (xfer_s) begin
      if (last_s) begin
        word_idx_r <= {IDX_W{1'b0}};
        blocks_cnt <= blocks_cnt + CNT_W'(1);
      end else begin
        word_idx_r <= word_idx_r + 1'b1;
      end
    end
  end

  // Sticky flags; a new event wins over a same-cycle clear
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      overflow <= 1'b0;
    end else if (drop_s) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef AES_OUT_COMPLEMENT_CHECK_EN
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      cmp_err <= 1'b0;
    end else if (cmp_bad_s) begin
      cmp_err <= 1'b1;
    end else if (ovf_clr) begin
      cmp_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer (WORD_W=32, DEPTH=2); inputs change
// and outputs are sampled on the falling clock edge.
module tb_aes_out_serializer;

  logic         AES_clk = 1'b0;
  logic         AES_rst;
  logic         AES_data_out_valid;
  logic [127:0] AES_data_out;
  logic         out_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic         overflow;
  logic         ovf_clr;
  logic [15:0]  blocks_cnt;
`ifdef AES_OUT_COMPLEMENT_CHECK_EN
  logic         flip;
  logic [127:0] AES_data_out_complementary;
  logic         cmp_err;
  assign AES_data_out_complementary = ~AES_data_out ^ {127'b0, flip};
`endif

  aes_out_serializer #(.WORD_W(32), .DEPTH(2), .CNT_W(16)) dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .AES_data_out_valid (AES_data_out_valid),
    .AES_data_out       (AES_data_out),
    .out_ready          (out_ready),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .out_last           (out_last),
    .overflow           (overflow),
    .ovf_clr            (ovf_clr),
    .blocks_cnt         (blocks_cnt)
`ifdef AES_OUT_COMPLEMENT_CHECK_EN
    ,
    .AES_data_out_complementary (AES_data_out_complementary),
    .cmp_err                    (cmp_err)
`endif
  );

  always #5 AES_clk = ~AES_clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] BLK_X = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] BLK_D = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BLK_A = 128'hA0000001_A0000002_A0000003_A0000004;
  localparam logic [127:0] BLK_B = 128'hB0000001_B0000002_B0000003_B0000004;
  localparam logic [127:0] BLK_C = 128'hC0000001_C0000002_C0000003_C0000004;
  localparam logic [127:0] BLK_E = 128'hE0000001_E0000002_E0000003_E0000004;
  localparam logic [127:0] BLK_F = 128'hF0000001_F0000002_F0000003_F0000004;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge AES_clk);
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int w);
    logic [127:0] t;
    t = blk >> (32 * (3 - w));
    return t[31:0];
  endfunction

  // Present a block for one cycle
  task automatic pulse(input logic [127:0] blk);
    AES_data_out_valid = 1'b1;
    AES_data_out       = blk;
    tick();
    AES_data_out_valid = 1'b0;
  endtask

  // With out_ready held high, expect the four words of blk on consecutive cycles
  task automatic expect_block(input string tag, input logic [127:0] blk);
    for (int w = 0; w < 4; w++) begin
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_data"}, out_data, word_of(blk, w));
      check({tag, "_last"}, out_last, (w == 3));
      tick();
    end
  endtask

  initial begin
    logic [31:0] exp_x [4];
    exp_x = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    AES_rst = 1'b1; AES_data_out_valid = 1'b0; AES_data_out = 128'h0;
    out_ready = 1'b0; ovf_clr = 1'b0;
`ifdef AES_OUT_COMPLEMENT_CHECK_EN
    flip = 1'b0;
`endif
    tick(); tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 32'h0);
    check("rst_last", out_last, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_cnt", blocks_cnt, 16'd0);
`ifdef AES_OUT_COMPLEMENT_CHECK_EN
    check("rst_cmp", cmp_err, 1'b0);
`endif
    AES_rst = 1'b0;
    tick();

    // Single block with the sink always ready
    out_ready = 1'b1;
    check("idle_valid", out_valid, 1'b0);
    pulse(BLK_X);
    for (int w = 0; w < 4; w++) begin
      check("x_valid", out_valid, 1'b1);
      check("x_data", out_data, exp_x[w]);
      check("x_last", out_last, (w == 3));
      tick();
    end
    check("x_done_valid", out_valid, 1'b0);
    check("x_cnt", blocks_cnt, 16'd1);

    // Alternating backpressure
    out_ready = 1'b0;
    pulse(BLK_D);
    for (int i = 0; i < 8; i++) begin
      out_ready = i[0];
      check("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, word_of(BLK_D, i / 2));
      check("bp_last", out_last, ((i / 2) == 3));
      tick();
    end
    out_ready = 1'b1;
    check("bp_done_valid", out_valid, 1'b0);
    check("bp_cnt", blocks_cnt, 16'd2);

    // Overflow: third block dropped while the sink stalls
    out_ready = 1'b0;
    pulse(BLK_A);
    pulse(BLK_B);
    pulse(BLK_C);
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", out_data, word_of(BLK_A, 0));
    out_ready = 1'b1;
    expect_block("ovf_a", BLK_A);
    expect_block("ovf_b", BLK_B);
    check("ovf_drained", out_valid, 1'b0);
    check("ovf_cnt", blocks_cnt, 16'd4);
    check("ovf_sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 1'b0);

    // Full FIFO accepts a block on the cycle the head's last word leaves
    out_ready = 1'b0;
    pulse(BLK_A);
    pulse(BLK_B);
    out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      check("fp_a_data", out_data, word_of(BLK_A, w));
      tick();
    end
    check("fp_a_last", out_last, 1'b1);
    pulse(BLK_C);
    check("fp_ovf", overflow, 1'b0);
    expect_block("fp_b", BLK_B);
    expect_block("fp_c", BLK_C);
    check("fp_drained", out_valid, 1'b0);
    check("fp_cnt", blocks_cnt, 16'd7);

    // Reset in the middle of a block
    pulse(BLK_E);
    check("mid_w0", out_data, word_of(BLK_E, 0));
    tick();
    check("mid_w1", out_data, word_of(BLK_E, 1));
    tick();
    AES_rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_cnt", blocks_cnt, 16'd0);
    check("mid_rst_data", out_data, 32'h0);
    tick();
    AES_rst = 1'b0;
    tick();
    check("post_rst_valid", out_valid, 1'b0);
    pulse(BLK_F);
    expect_block("post_rst", BLK_F);
    check("post_rst_cnt", blocks_cnt, 16'd1);

`ifdef AES_OUT_COMPLEMENT_CHECK_EN
    // Complement check: good pair passes, one flipped bit drops the block
    pulse(BLK_A);
    expect_block("cmp_ok", BLK_A);
    check("cmp_ok_err", cmp_err, 1'b0);
    flip = 1'b1;
    pulse(BLK_B);
    flip = 1'b0;
    check("cmp_err_set", cmp_err, 1'b1);
    check("cmp_no_out", out_valid, 1'b0);
    check("cmp_no_ovf", overflow, 1'b0);
    tick();
    check("cmp_still_idle", out_valid, 1'b0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("cmp_clr", cmp_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
- Downstream stage of AES_top.
- Captures each 128-bit result on its one-cycle AES_data_out_valid pulse into a small block FIFO.
- Emits each block as WORD_W-bit words, most-significant word first, on a valid/ready stream toward the host bus interface.
- Flags and counts dropped blocks, and counts emitted blocks.

Parameters:
- WORD_W, 32, output word width; legal values 8/16/32/64/128. NW = 128/WORD_W words per block.
- DEPTH, 2, number of 128-bit blocks buffered; power of two, minimum 1.
- CNT_W, 16, width of blocks_cnt.

Ports:
- AES_clk  in  1  clock.
- AES_rst  in  1  asynchronous reset, active-high.
- AES_data_out_valid  in  1  one-cycle pulse from AES_top; result present.
- AES_data_out  in  128  ciphertext from AES_top.
- out_ready  in  1  sink accepts the current word.
- out_valid  out  1  out_data holds a valid word.
- out_data  out  WORD_W  current word.
- out_last  out  1  current word is word NW-1 of its block.
- overflow  out  1  sticky; a block was dropped.
- ovf_clr  in  1  clears overflow.
- blocks_cnt  out  CNT_W  blocks fully emitted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; word_idx=0.
  - out_valid=0, out_data=0, out_last=0, overflow=0, blocks_cnt=0.
  - A partially emitted block is discarded.
- Push: on a clock edge with AES_data_out_valid=1 the block is written if either:
  - count<DEPTH, or
  - count==DEPTH and the last word of the head block handshakes in the same cycle.
- Drop: otherwise the block is not written, FIFO state is unchanged, and overflow is set.
- Latency: a block pushed at edge N gives out_valid=1 during the cycle after edge N, provided the FIFO was empty.
- out_valid = (count!=0).
- out_data = head[127-WORD_W*word_idx -: WORD_W].
- out_last = out_valid && (word_idx==NW-1).
- Handshake: a word transfers when out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - out_ready is ignored while out_valid=0.
- Word index on each handshake:
  - word_idx<NW-1: word_idx increments.
  - word_idx==NW-1: word_idx returns to 0, the head pops, and blocks_cnt increments (wraps).
- Push and pop in the same cycle: count unchanged; the new block goes to the tail; read and write pointers both advance.
- overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr=1 clears it.
- WORD_W=128: NW=1, and every word has out_last=1.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: AES_OUT_COMPLEMENT_CHECK_EN (fault-detection mode).
- When defined, two extra ports exist:
  - AES_data_out_complementary (in, 128).
  - cmp_err (out, 1, sticky, cleared by ovf_clr, reset 0).
- On each AES_data_out_valid pulse, if AES_data_out_complementary != ~AES_data_out:
  - cmp_err sets;
  - the block is dropped (not pushed) and does not set overflow.
- When undefined, neither port exists and every pulse is treated as a push candidate.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128;
  - block typedef (logic [127:0]);
  - function words_per_block(WORD_W).
- One sub-module, aes_blk_fifo:
  - DEPTH x 128 storage, pointers and count;
  - ports: push, pop, wdata, head, count, full, empty.
- Top level holds word_idx, output muxing, overflow, blocks_cnt and the complement check.

Test Plan:
- Single block, out_ready=1: pulse with 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a -> out_valid rises the next cycle; words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on consecutive cycles; out_last on the 4th word only; blocks_cnt=1.
- Backpressure: out_ready toggles 0/1 each cycle -> each word held stable while ready=0; 4 handshakes over 8 cycles; order unchanged.
- Overflow: out_ready=0, three pulses with blocks A, B, C -> A and B stored; overflow=1; after release, output is A then B only; ovf_clr pulse -> overflow=0.
- Full with simultaneous pop: FIFO full; a pulse with block C in the same cycle as head's last-word handshake -> C accepted; overflow stays 0; output sequence is B then C.
- Reset mid-block: assert AES_rst after 2 words of a block -> out_valid=0 and blocks_cnt=0 immediately; after release, the next pulse starts at word 0.
- With AES_OUT_COMPLEMENT_CHECK_EN: complementary=~data -> normal output. Complementary with bit 0 flipped -> cmp_err=1; no output words; overflow=0.
